// File: rtl/seg7_reader.sv
// Recovers 0-19 from an active-low 7-segment bus: strobed samples must hold for
// STABLE_CYCLES in a row; each accepted pattern is decoded once into a one-entry valid/ready buffer.
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] Segments,
    input  logic       seg_strobe,
    output logic [4:0] binNum,
    output logic       blank,
    output logic       invalid,
    output logic       num_valid,
    input  logic       num_ready,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        LOCKED
    } state_t;

    typedef struct packed {
        logic [4:0] num;
        logic       blank;
        logic       invalid;
    } decode_t;

    localparam logic [3:0] STABLE    = 4'(STABLE_CYCLES);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    state_t     state, state_next;
    logic [6:0] prev, prev_next;
    logic [3:0] count, count_next;
    logic       accept;
    decode_t    dec;

    function automatic decode_t decode(input logic [6:0] seg);
        decode_t d;
        d = '{num: 5'd31, blank: 1'b0, invalid: 1'b0};
        case (seg)
            7'b1000000: d.num = 5'd0;
            7'b1111001: d.num = 5'd1;
            7'b0100100: d.num = 5'd2;
            7'b0110000: d.num = 5'd3;
            7'b0011001: d.num = 5'd4;
            7'b0010010: d.num = 5'd5;
            7'b0000010: d.num = 5'd6;
            7'b1111000: d.num = 5'd7;
            7'b0000000: d.num = 5'd8;
            7'b0010000: d.num = 5'd9;
            7'b0001000: d.num = 5'd10;
            7'b0000011: d.num = 5'd11;
            7'b1000110: d.num = 5'd12;
            7'b0100001: d.num = 5'd13;
            7'b0000110: d.num = 5'd14;
            7'b0001110: d.num = 5'd15;
            7'b1000010: d.num = 5'd16;
            7'b0001001: d.num = 5'd17;
            7'b1100001: d.num = 5'd18;
            7'b1000111: d.num = 5'd19;
            SEG_BLANK:  d.blank = 1'b1;
            default:    d.invalid = 1'b1;
        endcase
        return d;
    endfunction

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        prev_next  = prev;
        count_next = count;
        accept     = 1'b0;
        if (seg_strobe) begin
            case (state)
                IDLE: begin
                    prev_next  = Segments;
                    count_next = 4'd1;
                    state_next = TRACK;
                end
                TRACK: begin
                    if (Segments == prev) begin
                        if (count != 4'hF) count_next = count + 4'd1;
                    end else begin
                        prev_next  = Segments;
                        count_next = 4'd1;
                    end
                end
                LOCKED: begin
                    if (Segments != prev) begin
                        prev_next  = Segments;
                        count_next = 4'd1;
                        state_next = TRACK;
                    end
                end
                default: state_next = IDLE;
            endcase
            // Checked after the update so a run of one accepts on its first sample.
            if (state_next == TRACK && count_next == STABLE) begin
                accept     = 1'b1;
                state_next = LOCKED;
            end
        end
    end

    assign dec = decode(Segments);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            prev  <= SEG_BLANK;
            count <= 4'd0;
        end else begin
            state <= state_next;
            prev  <= prev_next;
            count <= count_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            binNum    <= 5'd31;
            blank     <= 1'b0;
            invalid   <= 1'b0;
            num_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (accept) begin
                // A handshake this cycle frees the slot, so the new result loads without a bubble.
                if (!num_valid || num_ready) begin
                    binNum    <= dec.num;
                    blank     <= dec.blank;
                    invalid   <= dec.invalid;
                    num_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (num_valid && num_ready) begin
                num_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: stability filter, decode table, buffer handshake,
// overflow and asynchronous reset, against hand-computed expectations.
module tb_seg7_reader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] Segments;
    logic       seg_strobe;
    logic [4:0] binNum;
    logic       blank;
    logic       invalid;
    logic       num_valid;
    logic       num_ready;
    logic       overflow;

    int tests = 0;
    int fails = 0;
    int res_cnt = 0;
    int ovf_cnt = 0;
    logic [4:0] last_bin = 5'd0;

    localparam logic [6:0] NEIGHBOUR = 7'b1010101;

    seg7_reader #(.STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Segments   (Segments),
        .seg_strobe (seg_strobe),
        .binNum     (binNum),
        .blank      (blank),
        .invalid    (invalid),
        .num_valid  (num_valid),
        .num_ready  (num_ready),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so at negedge they hold what the next edge will see.
    always @(negedge clk) begin
        if (reset_n && num_valid && num_ready) begin
            res_cnt++;
            last_bin = binNum;
        end
        if (overflow) ovf_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [6:0] pat, input int n);
        for (int k = 0; k < n; k++) begin
            Segments   = pat;
            seg_strobe = 1'b1;
            @(posedge clk);
            #1;
            seg_strobe = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [6:0] pats [22];
    int snap;

    initial begin
        pats = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110,
                 7'b0001110, 7'b1000010, 7'b0001001, 7'b1100001, 7'b1000111,
                 7'b1111111, 7'b0111111};

        reset_n    = 1'b0;
        Segments   = 7'b1111111;
        seg_strobe = 1'b0;
        num_ready  = 1'b0;
        idle(2);
        check("rst_bin", 16'(binNum), 16'd31);
        check("rst_blank", 16'(blank), 16'd0);
        check("rst_invalid", 16'(invalid), 16'd0);
        check("rst_valid", 16'(num_valid), 16'd0);
        check("rst_overflow", 16'(overflow), 16'd0);
        reset_n = 1'b1;
        idle(1);

        // Basic accept: value 3 after four stable strobes, then no repeat while held.
        num_ready = 1'b1;
        strobe(7'b0110000, 3);
        check("basic_early", 16'(num_valid), 16'd0);
        strobe(7'b0110000, 1);
        check("basic_valid", 16'(num_valid), 16'd1);
        check("basic_bin", 16'(binNum), 16'd3);
        check("basic_flags", 16'({blank, invalid}), 16'd0);
        strobe(7'b0110000, 10);
        check("basic_once", 16'(res_cnt), 16'd1);

        // Glitch in the middle of a run restarts the count.
        snap = res_cnt;
        strobe(7'b1111001, 3);
        strobe(7'b1111000, 1);
        strobe(7'b1111001, 3);
        check("glitch_early", 16'(num_valid), 16'd0);
        strobe(7'b1111001, 1);
        check("glitch_valid", 16'(num_valid), 16'd1);
        idle(1);
        check("glitch_count", 16'(res_cnt - snap), 16'd1);
        check("glitch_bin", 16'(last_bin), 16'd1);

        // Table sweep: {num_valid, invalid, blank, binNum}.
        for (int i = 0; i < 22; i++) begin
            logic [7:0] exp;
            if (i < 20)       exp = {1'b1, 1'b0, 1'b0, 5'(i)};
            else if (i == 20) exp = {1'b1, 1'b0, 1'b1, 5'd31};
            else              exp = {1'b1, 1'b1, 1'b0, 5'd31};
            strobe(pats[i], 4);
            check($sformatf("sweep_%0d", i), 16'({num_valid, invalid, blank, binNum}), 16'(exp));
            strobe(NEIGHBOUR, 1);
        end

        // Backpressure: second accept is dropped and flagged.
        num_ready = 1'b0;
        snap = ovf_cnt;
        strobe(7'b0010010, 4);
        check("bp_first", 16'({num_valid, binNum}), 16'({1'b1, 5'd5}));
        check("bp_no_ovf", 16'(overflow), 16'd0);
        strobe(7'b0000000, 4);
        check("bp_ovf", 16'(overflow), 16'd1);
        check("bp_keep", 16'({num_valid, binNum}), 16'({1'b1, 5'd5}));
        idle(1);
        check("bp_ovf_pulse", 16'(overflow), 16'd0);
        check("bp_ovf_count", 16'(ovf_cnt - snap), 16'd1);
        num_ready = 1'b1;
        idle(1);
        check("bp_drain", 16'(num_valid), 16'd0);

        // Accept coinciding with handshake: no bubble, no drop.
        num_ready = 1'b0;
        strobe(7'b1000110, 4);
        check("sim_hold12", 16'({num_valid, binNum}), 16'({1'b1, 5'd12}));
        strobe(7'b0001001, 3);
        num_ready = 1'b1;
        snap = ovf_cnt;
        strobe(7'b0001001, 1);
        check("sim_new", 16'({num_valid, binNum}), 16'({1'b1, 5'd17}));
        check("sim_no_ovf", 16'(overflow), 16'd0);
        idle(1);
        check("sim_drain", 16'(num_valid), 16'd0);
        check("sim_ovf_count", 16'(ovf_cnt - snap), 16'd0);

        // Asynchronous reset mid-run with a pending result.
        num_ready = 1'b0;
        strobe(7'b0000110, 4);
        check("rr_pending", 16'({num_valid, binNum}), 16'({1'b1, 5'd14}));
        strobe(7'b1000111, 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("rr_valid", 16'(num_valid), 16'd0);
        check("rr_bin", 16'(binNum), 16'd31);
        idle(1);
        reset_n   = 1'b1;
        num_ready = 1'b1;
        strobe(7'b1000111, 3);
        check("rr_partial_lost", 16'(num_valid), 16'd0);
        strobe(7'b1000111, 1);
        check("rr_fresh", 16'({num_valid, invalid, blank, binNum}), 16'({3'b100, 5'd19}));
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
Name: seg7_reader

Overview:
- Recovers binary values 0–19 from an active-low 7-segment bus.
- Samples the bus on a strobe and requires the pattern to hold for STABLE_CYCLES consecutive samples.
- Decodes each accepted pattern once and presents it through a one-entry valid/ready output buffer.
- Sits on the observation side of the display path: display checking, loopback from the digit driver, and host readback.

Parameters:
STABLE_CYCLES, 4, consecutive identical strobed samples needed to accept a pattern (legal range 1–15)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
Segments  input  7  segment pattern, active low; bit0 = LED A … bit6 = LED G
seg_strobe  input  1  sample enable; Segments is sampled only in cycles where this is 1
binNum  output  5  decoded value 0–19; 31 when blank or invalid
blank  output  1  accepted pattern was all-off (7'b1111111)
invalid  output  1  accepted pattern is neither in the table nor blank
num_valid  output  1  output buffer holds an unconsumed result
num_ready  input  1  consumer accepts the result when num_valid & num_ready
overflow  output  1  one-cycle pulse: an accepted result was dropped because the buffer was full

Behaviour:
- Asynchronous reset (reset_n = 0):
  - Outputs: binNum = 31, blank = 0, invalid = 0, num_valid = 0, overflow = 0.
  - Internal: FSM = IDLE, stability counter = 0, previous-sample register = 7'b1111111.
- Decode table (Segments → binNum), patterns are 6:0 = GFEDCBA:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - 10 = 0001000, 11 = 0000011, 12 = 1000110, 13 = 0100001, 14 = 0000110
  - 15 = 0001110, 16 = 1000010, 17 = 0001001, 18 = 1100001, 19 = 1000111
  - Blank: 1111111 → binNum = 31, blank = 1, invalid = 0.
  - Any other pattern → binNum = 31, blank = 0, invalid = 1.
- FSM states: IDLE, TRACK, LOCKED. Nothing happens in cycles where seg_strobe = 0.
  - IDLE, strobe: store the sample, count = 1, go to TRACK.
  - TRACK, strobe with sample == previous: count += 1.
  - TRACK, strobe with sample != previous: store the sample, count = 1, stay in TRACK.
  - Accept condition: after the update, count == STABLE_CYCLES. Then raise the accept pulse and go to LOCKED.
  - LOCKED, strobe with sample == previous: no action. Each stable run produces exactly one accept.
  - LOCKED, strobe with sample != previous: store the sample, count = 1, go to TRACK.
  - STABLE_CYCLES = 1: the first strobed sample of any new pattern is accepted in that same cycle.
- Counter:
  - 4 bits wide; saturates and never wraps.
  - Counts strobed samples only; gaps in seg_strobe do not reset it.
- Output buffer:
  - On accept, the decode of the sampled pattern is registered; num_valid = 1 starting the next cycle.
  - Latency: the strobed sample that completes the run is followed by num_valid high 1 cycle later.
  - binNum, blank and invalid hold steady while num_valid = 1 and num_ready = 0.
  - Handshake (num_valid & num_ready) with no accept in the same cycle: num_valid = 0 the next cycle.
  - Accept in the same cycle as a handshake: the new result loads and num_valid stays 1 (no bubble, no drop).
  - Accept while num_valid = 1 and num_ready = 0: the new result is discarded, the old result is kept, and overflow pulses high for 1 cycle.
  - Accept while num_valid = 0: the result loads and overflow = 0.
- Reset asserted mid-run or mid-handshake: everything returns to reset values immediately. The partial run and any held result are lost. The first strobe after release behaves as from IDLE.

Test Plan:
- STABLE_CYCLES = 4, num_ready = 1; strobe Segments = 0110000 for 4 consecutive cycles → num_valid high the cycle after the 4th strobe, binNum = 3, blank = 0, invalid = 0; holding the pattern 10 more strobes → no further num_valid.
- Glitch: strobe 1111001 ×3, then 1111000 ×1, then 1111001 ×4 → exactly one result, binNum = 1, after the final 4th sample; no result for 7.
- Table sweep: for each of the 20 patterns, the blank pattern, and 0111111 (invalid), apply ×4 strobes, each followed by a distinct neighbour → binNum = 0..19 matching the table; blank → 31 with blank = 1; 0111111 → 31 with invalid = 1.
- Backpressure: num_ready = 0; accept 5 (0010010), then accept 8 (0000000) → binNum stays 5, overflow pulses 1 cycle at the second accept; raise num_ready → handshake, num_valid drops.
- Simultaneous accept and handshake: num_valid = 1 holding 12, num_ready = 1 in the same cycle a 0001001 run completes → next cycle num_valid = 1, binNum = 17, overflow = 0.
- Reset: assert reset_n = 0 asynchronously after 2 of 4 samples of 1000111, with a prior result pending → immediate num_valid = 0, binNum = 31; after release, 4 fresh strobes of 1000111 → binNum = 19.
